// File: rtl/demux_route_sequencer.sv
// -----------------------------------------------------------------------------
// demux_route_sequencer
//
// Purpose:
//   Upstream driver for a 1-to-NUM_CH demultiplexer. The block takes a serial
//   bit stream over a valid/ready handshake. It routes successive bits to the
//   enabled channels in ascending channel order, one bit per enabled channel
//   per frame. The demux data input (i) and select (s) are driven from
//   registers. Frame completion and bad-configuration events are reported as
//   single-cycle pulses.
//
// Parameters:
//   NUM_CH     number of demux output channels; must equal 2**SEL_W
//   SEL_W      select width driven to the demux
//
// Ports:
//   clk         in   1       clock, all state updates on the rising edge
//   rst         in   1       synchronous active-high reset
//   start       in   1       begin a frame; honoured only while idle
//   ch_mask     in   NUM_CH  enabled channels, sampled when start is accepted
//   din         in   1       serial data bit
//   din_valid   in   1       din is valid this cycle
//   din_ready   out  1       sequencer accepts din this cycle
//   i           out  1       registered data to the demux input
//   s           out  SEL_W   registered select to the demux
//   busy        out  1       high while a frame is in progress
//   frame_done  out  1       one-cycle pulse after the last bit of a frame
//   err         out  1       one-cycle pulse when start arrives with ch_mask == 0
//
// Configuration macro:
//   DEMUX_SEQ_RTZ_EN  When defined, the design uses return-to-zero data.
//                     i is 1 only in the cycle right after an accept. In every
//                     later cycle without an accept, i falls back to 0, so each
//                     routed bit becomes a single-cycle pulse on the demux
//                     output. s still holds.
//                     When undefined, i holds the last routed bit.
// -----------------------------------------------------------------------------
module demux_route_sequencer #(
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              i,
    output logic [SEL_W-1:0]  s,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t             r_state,      w_state_nxt;
    logic [SEL_W-1:0]   r_ptr,        w_ptr_nxt;
    logic [NUM_CH-1:0]  r_mask,       w_mask_nxt;
    logic               r_i,          w_i_nxt;
    logic [SEL_W-1:0]   r_s,          w_s_nxt;
    logic               r_frame_done, w_frame_done_nxt;
    logic               r_err,        w_err_nxt;

    logic [NUM_CH-1:0]  w_above;      // enabled channels strictly above r_ptr
    logic               w_accept;

    // Index of the lowest set bit. Callers only pass non-zero vectors.
    // The descending scan leaves the lowest hit as the final assignment.
    function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
        lowest_set = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (v[k]) begin
                lowest_set = SEL_W'(k);
            end
        end
    endfunction

    assign w_accept = (r_state == ST_SCAN) && din_valid;

    always_comb begin
        w_above = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_above[k] = r_mask[k] && (k > int'(r_ptr));
        end
    end

    // NOTE: every signal written in this block gets a default before the case.
    // Without those defaults, a path that leaves a signal unassigned would
    // infer a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_mask_nxt       = r_mask;
        w_s_nxt          = r_s;
        w_frame_done_nxt = 1'b0;
        w_err_nxt        = 1'b0;
`ifdef DEMUX_SEQ_RTZ_EN
        w_i_nxt          = 1'b0;    // any cycle without an accept returns i to 0
`else
        w_i_nxt          = r_i;     // i holds the last routed bit
`endif

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (|ch_mask) begin
                        w_mask_nxt  = ch_mask;
                        w_ptr_nxt   = lowest_set(ch_mask);
                        w_state_nxt = ST_SCAN;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                end
            end

            ST_SCAN: begin
                // start and ch_mask are deliberately ignored mid-frame.
                if (w_accept) begin
                    w_i_nxt = din;
                    w_s_nxt = r_ptr;
                    if (|w_above) begin
                        w_ptr_nxt = lowest_set(w_above);
                    end else begin
                        // No wrap-around: the last enabled channel ends the frame.
                        w_state_nxt      = ST_IDLE;
                        w_frame_done_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge, whatever order the statements
    // appear in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_mask       <= '0;
            r_i          <= 1'b0;
            r_s          <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_mask       <= w_mask_nxt;
            r_i          <= w_i_nxt;
            r_s          <= w_s_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign din_ready  = (r_state == ST_SCAN);
    assign busy       = (r_state == ST_SCAN);
    assign i          = r_i;
    assign s          = r_s;
    assign frame_done = r_frame_done;
    assign err        = r_err;

endmodule

// File: tb/tb_demux_route_sequencer.sv
// -----------------------------------------------------------------------------
// tb_demux_route_sequencer
//
// Purpose:
//   Directed testbench for demux_route_sequencer. Each expected value is
//   computed by hand from the block's behaviour.
//
//   Inputs change 1 ns after a rising edge. Outputs are sampled at that same
//   point, before any new drive, so every sample shows the state produced by
//   the edge just taken.
//
//   Where the expected value of i depends on DEMUX_SEQ_RTZ_EN, the
//   expectation follows the macro.
// -----------------------------------------------------------------------------
module tb_demux_route_sequencer;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

`ifdef DEMUX_SEQ_RTZ_EN
    localparam bit RTZ = 1'b1;
`else
    localparam bit RTZ = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [NUM_CH-1:0] ch_mask;
    logic              din;
    logic              din_valid;
    logic              din_ready;
    logic              i;
    logic [SEL_W-1:0]  s;
    logic              busy;
    logic              frame_done;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    demux_route_sequencer #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ch_mask    (ch_mask),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .i          (i),
        .s          (s),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Value of i in a cycle without an accept, given the last routed bit.
    function automatic logic idle_i(input logic last_bit);
        return RTZ ? 1'b0 : last_bit;
    endfunction

    // Full state check in one call.
    task automatic check_out(input string tag, input logic e_i, input logic [SEL_W-1:0] e_s,
                             input logic e_busy, input logic e_done, input logic e_err);
        check({tag, ".i"},     i,          e_i);
        check({tag, ".s"},     s,          e_s);
        check({tag, ".busy"},  busy,       e_busy);
        check({tag, ".ready"}, din_ready,  e_busy);
        check({tag, ".done"},  frame_done, e_done);
        check({tag, ".err"},   err,        e_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bits1;
        logic [2:0] sel2 [3];
        logic       bit2 [3];

        rst = 1'b1; start = 1'b0; ch_mask = '0; din = 1'b0; din_valid = 1'b0;
        tick; tick;
        check_out("reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick;
        check_out("post_reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        // 1: full mask, bits 1,0,1,1,0,0,1,0 back to back
        bits1 = 8'b0100_1101;       // bits1[k] is the k-th bit sent
        start = 1'b1; ch_mask = 8'hFF;
        tick;
        start = 1'b0;
        check("t1.busy_after_start", busy, 1'b1);
        check("t1.ready_after_start", din_ready, 1'b1);
        din_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            din = bits1[k];
            tick;
            check($sformatf("t1.s%0d", k),    s,          k);
            check($sformatf("t1.i%0d", k),    i,          bits1[k]);
            check($sformatf("t1.done%0d", k), frame_done, (k == 7));
            check($sformatf("t1.busy%0d", k), busy,       (k != 7));
        end
        din_valid = 1'b0;
        tick;
        check_out("t1.after", idle_i(1'b0), 3'd7, 1'b0, 1'b0, 1'b0);

        // 2: sparse mask 0x29 -> channels 0,3,5
        sel2 = '{3'd0, 3'd3, 3'd5};
        bit2 = '{1'b1, 1'b1, 1'b0};
        start = 1'b1; ch_mask = 8'h29;
        tick;
        start = 1'b0; din_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din = bit2[k];
            tick;
            check($sformatf("t2.s%0d", k),    s,          sel2[k]);
            check($sformatf("t2.i%0d", k),    i,          bit2[k]);
            check($sformatf("t2.done%0d", k), frame_done, (k == 2));
        end
        din_valid = 1'b0;
        tick;
        check_out("t2.after", 1'b0, 3'd5, 1'b0, 1'b0, 1'b0);

        // 3: empty mask -> err pulse, stays idle, i/s untouched
        start = 1'b1; ch_mask = 8'h00;
        tick;
        start = 1'b0;
        check_out("t3.err", 1'b0, 3'd5, 1'b0, 1'b0, 1'b1);
        tick;
        check_out("t3.after", 1'b0, 3'd5, 1'b0, 1'b0, 1'b0);

        // 4: reset mid-frame after the 4th accept
        start = 1'b1; ch_mask = 8'hFF;
        tick;
        start = 1'b0; din_valid = 1'b1; din = 1'b1;
        for (int k = 0; k < 4; k++) tick;
        check_out("t4.pre_rst", 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        din_valid = 1'b0; rst = 1'b1;
        tick;
        rst = 1'b0;
        check_out("t4.rst", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick;
        check_out("t4.no_done", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; ch_mask = 8'hFF;
        tick;
        start = 1'b0; din_valid = 1'b1; din = 1'b1;
        tick;
        check_out("t4.restart", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
        din_valid = 1'b0; rst = 1'b1;
        tick;
        rst = 1'b0;

        // Single-channel mask: one accept ends the frame
        start = 1'b1; ch_mask = 8'h80;
        tick;
        start = 1'b0; din_valid = 1'b1; din = 1'b1;
        tick;
        check_out("single", 1'b1, 3'd7, 1'b0, 1'b1, 1'b0);

        // Back to back: start during the frame_done cycle is accepted
        din_valid = 1'b0; start = 1'b1; ch_mask = 8'h12;
        tick;
        start = 1'b0;
        check_out("b2b.start", idle_i(1'b1), 3'd7, 1'b1, 1'b0, 1'b0);

        // 5: gaps and ignored mid-frame start (mask 0x12 -> channels 1,4)
        din_valid = 1'b1; din = 1'b1;
        tick;
        check_out("t5.first", 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        din_valid = 1'b0; din = 1'b0; start = 1'b1; ch_mask = 8'h01;
        tick;
        check_out("t5.gap0", idle_i(1'b1), 3'd1, 1'b1, 1'b0, 1'b0);
        tick;
        check_out("t5.gap1", idle_i(1'b1), 3'd1, 1'b1, 1'b0, 1'b0);
        start = 1'b0; din_valid = 1'b1; din = 1'b0;
        tick;
        check_out("t5.last", 1'b0, 3'd4, 1'b0, 1'b1, 1'b0);
        din_valid = 1'b0;
        tick;

        // 6: mask 0x03, bits 1,1 with a one-cycle gap
        start = 1'b1; ch_mask = 8'h03;
        tick;
        start = 1'b0; din_valid = 1'b1; din = 1'b1;
        tick;
        check_out("t6.a0", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
        din_valid = 1'b0;
        tick;
        check_out("t6.gap", idle_i(1'b1), 3'd0, 1'b1, 1'b0, 1'b0);
        din_valid = 1'b1; din = 1'b1;
        tick;
        check_out("t6.a1", 1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
        din_valid = 1'b0;
        tick;
        check_out("t6.after", idle_i(1'b1), 3'd1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
